// File: rtl/fft_stage_sequencer.sv
// Scheduler for an in-place radix-2 DIT FFT: load, log2(N) butterfly stages, then readout.
// Requests are registered (start->load_en 1 cycle, load_done->issue 1 cycle); issue stalls on issue_ready and the writeback window.
module fft_stage_sequencer #(
   parameter int N             = 32,
   parameter int address_width = $clog2(N),
   parameter int max_inflight  = 8
) (
   input  logic                               clk,
   input  logic                               reset_n,
   input  logic                               start,
   output logic                               busy,
   output logic                               done,
   output logic                               load_en,
   input  logic                               load_done,
   output logic                               issue_valid,
   input  logic                               issue_ready,
   output logic [address_width-1:0]           addr_a,
   output logic [address_width-1:0]           addr_b,
   output logic [address_width-2:0]           tw_addr,
   output logic [$clog2(address_width)-1:0]   stage,
   input  logic                               wb_ack,
   output logic                               out_en,
   input  logic                               out_busy,
   output logic                               err
);
   localparam int L  = address_width;
   localparam int BW = L - 1;
   localparam int SW = $clog2(L);
   localparam int IW = $clog2(max_inflight + 1);

   localparam logic [2:0] S_IDLE   = 3'd0;
   localparam logic [2:0] S_LOAD   = 3'd1;
   localparam logic [2:0] S_ISSUE  = 3'd2;
   localparam logic [2:0] S_DRAIN  = 3'd3;
   localparam logic [2:0] S_OUTPUT = 3'd4;
   localparam logic [2:0] S_DONE   = 3'd5;

   localparam logic [IW-1:0] MAX_INF = IW'(max_inflight);
   localparam logic [BW-1:0] LAST_B  = {BW{1'b1}};
   localparam logic [SW-1:0] LAST_S  = SW'(L - 1);

   // Upper leg: insert a zero at bit s of the butterfly index.
   function automatic logic [L-1:0] calc_a(input logic [BW-1:0] b, input logic [SW-1:0] s);
      logic [L-1:0] be;
      logic [L-1:0] span;
      int           sh;
      sh     = int'(s);
      be     = {1'b0, b};
      span   = L'(1) << sh;
      calc_a = ((be >> sh) << (sh + 1)) | (be & (span - L'(1)));
   endfunction

   function automatic logic [BW-1:0] calc_tw(input logic [BW-1:0] b, input logic [SW-1:0] s);
      logic [BW-1:0] mask;
      int            sh;
      sh      = int'(s);
      mask    = ~({BW{1'b1}} << sh);
      calc_tw = (b & mask) << (BW - sh);
   endfunction

   logic [2:0]    state_q, state_d;
   logic [BW-1:0] b_q, b_d;
   logic [SW-1:0] stage_q, stage_d;
   logic [IW-1:0] inflight_q, inflight_d;
   logic          issue_valid_q, issue_valid_d;
   logic [L-1:0]  addr_a_q, addr_a_d;
   logic [L-1:0]  addr_b_q, addr_b_d;
   logic [BW-1:0] tw_q, tw_d;
   logic          seen_busy_q, seen_busy_d;
   logic          err_q, err_d;
   logic          hs;

   assign hs = issue_valid_q & issue_ready;

   always_comb begin
      inflight_d = inflight_q;
      if (hs && !wb_ack) begin
         inflight_d = inflight_q + IW'(1);
      end else if (!hs && wb_ack && inflight_q != '0) begin
         inflight_d = inflight_q - IW'(1);
      end
      err_d = err_q | (wb_ack && inflight_q == '0);
   end

   always_comb begin
      state_d     = state_q;
      b_d         = b_q;
      stage_d     = stage_q;
      seen_busy_d = seen_busy_q;
      case (state_q)
         S_IDLE: begin
            seen_busy_d = 1'b0;
            if (start) begin
               state_d = S_LOAD;
               stage_d = '0;
               b_d     = '0;
            end
         end
         S_LOAD: begin
            if (load_done) begin
               state_d = S_ISSUE;
               stage_d = '0;
               b_d     = '0;
            end
         end
         S_ISSUE: begin
            if (hs) begin
               if (b_q == LAST_B) begin
                  state_d = S_DRAIN;
               end else begin
                  b_d = b_q + BW'(1);
               end
            end
         end
         S_DRAIN: begin
            // Next stage reads what this stage wrote, so every writeback must land first.
            if (inflight_q == '0) begin
               if (stage_q != LAST_S) begin
                  stage_d = stage_q + SW'(1);
                  b_d     = '0;
                  state_d = S_ISSUE;
               end else begin
                  state_d = S_OUTPUT;
               end
            end
         end
         S_OUTPUT: begin
            if (out_busy) begin
               seen_busy_d = 1'b1;
            end else if (seen_busy_q) begin
               seen_busy_d = 1'b0;
               state_d     = S_DONE;
            end
         end
         S_DONE: begin
            state_d = S_IDLE;
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   always_comb begin
      issue_valid_d = (state_d == S_ISSUE) && (inflight_d != MAX_INF);
      addr_a_d      = addr_a_q;
      addr_b_d      = addr_b_q;
      tw_d          = tw_q;
      if (state_d == S_ISSUE) begin
         addr_a_d = calc_a(b_d, stage_d);
         addr_b_d = calc_a(b_d, stage_d) | (L'(1) << int'(stage_d));
         tw_d     = calc_tw(b_d, stage_d);
      end
   end

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         state_q       <= S_IDLE;
         b_q           <= '0;
         stage_q       <= '0;
         inflight_q    <= '0;
         issue_valid_q <= 1'b0;
         addr_a_q      <= '0;
         addr_b_q      <= '0;
         tw_q          <= '0;
         seen_busy_q   <= 1'b0;
         err_q         <= 1'b0;
      end else begin
         state_q       <= state_d;
         b_q           <= b_d;
         stage_q       <= stage_d;
         inflight_q    <= inflight_d;
         issue_valid_q <= issue_valid_d;
         addr_a_q      <= addr_a_d;
         addr_b_q      <= addr_b_d;
         tw_q          <= tw_d;
         seen_busy_q   <= seen_busy_d;
         err_q         <= err_d;
      end
   end

   assign busy        = (state_q != S_IDLE);
   assign done        = (state_q == S_DONE);
   assign load_en     = (state_q == S_LOAD);
   assign out_en      = (state_q == S_OUTPUT);
   assign issue_valid = issue_valid_q;
   assign addr_a      = addr_a_q;
   assign addr_b      = addr_b_q;
   assign tw_addr     = tw_q;
   assign stage       = stage_q;
   assign err         = err_q;

endmodule

// File: tb/tb_fft_stage_sequencer.sv
// Bench for fft_stage_sequencer at N=8, max_inflight=2: table, directed corner cases and randomized runs.
module tb_fft_stage_sequencer;
   localparam int N    = 8;
   localparam int L    = 3;
   localparam int MAXI = 2;
   localparam int NHS  = (N / 2) * L;

   logic       clk = 1'b0;
   logic       reset_n = 1'b0;
   logic       start = 1'b0;
   logic       busy, done, load_en, issue_valid, out_en, err;
   logic       load_done = 1'b0;
   logic       issue_ready = 1'b0;
   logic       wb_ack = 1'b0;
   logic       out_busy = 1'b0;
   logic [2:0] addr_a, addr_b;
   logic [1:0] tw_addr;
   logic [1:0] stage;

   always #5 clk = ~clk;

   fft_stage_sequencer #(.N(N), .address_width(L), .max_inflight(MAXI)) dut (
      .clk(clk), .reset_n(reset_n), .start(start), .busy(busy), .done(done),
      .load_en(load_en), .load_done(load_done), .issue_valid(issue_valid),
      .issue_ready(issue_ready), .addr_a(addr_a), .addr_b(addr_b), .tw_addr(tw_addr),
      .stage(stage), .wb_ack(wb_ack), .out_en(out_en), .out_busy(out_busy), .err(err)
   );

   typedef struct { int stg; int a; int b; int tw; } bfly_t;

   bfly_t tab[NHS];
   bfly_t ref_q[$];
   bfly_t hs_q[$];
   int    ack_q[$];
   int    checks = 0, errors = 0;
   int    cyc = 0, tb_inflight = 0, done_cnt = 0, stall_cnt = 0;
   int    ack_lo = 3, ack_hi = 3, late_idx = -1;
   bit    exp_err = 0, extra_ack = 0, hold_acks = 0, release_one = 0, ready_rand = 0;
   bit    prev_stall = 0;
   logic [31:0] prev_req;

   function automatic logic [31:0] pk(input bfly_t x);
      return {8'(x.stg), 8'(x.a), 8'(x.b), 8'(x.tw)};
   endfunction

   function automatic logic [31:0] cur_req();
      return {8'(stage), 8'(addr_a), 8'(addr_b), 8'(tw_addr)};
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // Commits this cycle's inputs, models the butterfly unit, then advances to the next negedge.
   task automatic tick();
      bit    hs;
      bfly_t e;
      if (stall_cnt > 0) begin
         issue_ready = 1'b0;
         stall_cnt--;
      end else if (ready_rand) begin
         issue_ready = ($urandom_range(0, 3) != 0);
      end else begin
         issue_ready = 1'b1;
      end
      wb_ack = 1'b0;
      if (extra_ack) begin
         wb_ack    = 1'b1;
         extra_ack = 0;
      end else if (ack_q.size() > 0 && ((!hold_acks && ack_q[0] <= cyc) || release_one)) begin
         wb_ack      = 1'b1;
         release_one = 0;
         void'(ack_q.pop_front());
      end
      hs = reset_n && issue_valid && issue_ready;
      if (reset_n && tb_inflight >= MAXI) check("cap_holds_valid", issue_valid, 0);
      if (hs) begin
         if (hs_q.size() > 0 && hs_q[$].stg != int'(stage)) check("drain_before_stage", tb_inflight, 0);
         e.stg = int'(stage); e.a = int'(addr_a); e.b = int'(addr_b); e.tw = int'(tw_addr);
         hs_q.push_back(e);
         ack_q.push_back(cyc + ((hs_q.size() - 1 == late_idx) ? 13 : int'($urandom_range(ack_lo, ack_hi))));
      end
      if (!reset_n) begin
         ack_q.delete();
         tb_inflight = 0;
         exp_err     = 0;
      end else begin
         if (wb_ack && tb_inflight == 0) exp_err = 1;
         else if (wb_ack) tb_inflight--;
         if (hs) tb_inflight++;
      end
      prev_stall = reset_n && issue_valid && !issue_ready;
      prev_req   = cur_req();
      @(negedge clk);
      cyc++;
      if (done) done_cnt++;
      if (prev_stall) begin
         check("stall_valid_held", issue_valid, 1);
         check("stall_req_stable", cur_req(), prev_req);
      end
   endtask

   // mode: 0 plain, 1 ready stall, 2 writeback cap, 3 late last writeback, 4 start while busy
   task automatic run_tx(input int mode, input bit use_table);
      int t;
      bit did;
      did = 0;
      hs_q.delete();
      done_cnt  = 0;
      hold_acks = (mode == 2);
      start = 1'b1; tick(); start = 1'b0;
      check("load_en_latency", load_en, 1);
      check("busy_after_start", busy, 1);
      repeat ($urandom_range(0, 4)) begin
         tick();
         check("load_en_held", load_en, 1);
      end
      load_done = 1'b1; tick(); load_done = 1'b0;
      check("first_valid_latency", issue_valid, 1);
      check("load_en_off", load_en, 0);
      t = 0;
      while (!out_en && t < 4000) begin
         if (mode == 1 && !did && hs_q.size() >= 5 && issue_valid) begin
            stall_cnt = 5;
            did = 1;
         end
         if (mode == 2 && !did && hs_q.size() == 2) begin
            repeat (6) tick();
            check("cap_issue_count", hs_q.size(), 2);
            check("cap_valid_low", issue_valid, 0);
            release_one = 1;
            repeat (6) tick();
            check("cap_one_more", hs_q.size(), 3);
            hold_acks = 0;
            did = 1;
         end
         if (mode == 3 && !did && hs_q.size() == N / 2) begin
            for (int i = 0; i < 10; i++) begin
               tick();
               check("late_ack_stage", stage, 0);
               check("late_ack_valid", issue_valid, 0);
            end
            did = 1;
         end
         start = (mode == 4 && !did && hs_q.size() >= 3);
         if (start) did = 1;
         tick();
         t++;
      end
      start     = 1'b0;
      hold_acks = 0;
      check("out_en_reached", out_en, 1);
      repeat ($urandom_range(0, 3)) begin
         tick();
         check("wait_busy_rise", {done, out_en}, 2'b01);
      end
      out_busy = 1'b1;
      repeat ($urandom_range(1, 5)) begin
         tick();
         check("out_en_while_busy", {done, out_en}, 2'b01);
      end
      out_busy = 1'b0;
      tick();
      check("done_pulse", done, 1);
      check("out_en_dropped", out_en, 0);
      check("busy_in_done", busy, 1);
      tick();
      check("done_one_cycle", done, 0);
      check("busy_idle", busy, 0);
      check("done_count", done_cnt, 1);
      check("issue_count", hs_q.size(), NHS);
      for (int k = 0; k < NHS && k < hs_q.size(); k++) begin
         if (use_table) check($sformatf("table_bfly%0d", k), pk(hs_q[k]), pk(tab[k]));
         else           check($sformatf("model_bfly%0d", k), pk(hs_q[k]), pk(ref_q[k]));
      end
      check("err_flag", err, exp_err);
   endtask

   initial begin
      int t;
      bfly_t e;
      tab[0]  = '{0, 0, 1, 0}; tab[1]  = '{0, 2, 3, 0}; tab[2]  = '{0, 4, 5, 0}; tab[3]  = '{0, 6, 7, 0};
      tab[4]  = '{1, 0, 2, 0}; tab[5]  = '{1, 1, 3, 2}; tab[6]  = '{1, 4, 6, 0}; tab[7]  = '{1, 5, 7, 2};
      tab[8]  = '{2, 0, 4, 0}; tab[9]  = '{2, 1, 5, 1}; tab[10] = '{2, 2, 6, 2}; tab[11] = '{2, 3, 7, 3};

      // Reference order: each stage pairs i with i+span wherever bit s of i is clear.
      for (int s = 0; s < L; s++) begin
         for (int i = 0; i < N; i++) begin
            if (((i / (1 << s)) % 2) == 0) begin
               e.stg = s;
               e.a   = i;
               e.b   = i + (1 << s);
               e.tw  = (i % (1 << s)) * (N / (2 * (1 << s)));
               ref_q.push_back(e);
            end
         end
      end

      reset_n = 1'b0;
      repeat (3) tick();
      check("rst_busy", busy, 0);        check("rst_done", done, 0);
      check("rst_load_en", load_en, 0);  check("rst_valid", issue_valid, 0);
      check("rst_addr_a", addr_a, 0);    check("rst_addr_b", addr_b, 0);
      check("rst_tw", tw_addr, 0);       check("rst_stage", stage, 0);
      check("rst_out_en", out_en, 0);    check("rst_err", err, 0);
      reset_n = 1'b1;
      repeat (2) tick();

      run_tx(0, 1);
      run_tx(1, 0);
      run_tx(2, 0);
      late_idx = N / 2 - 1;
      run_tx(3, 0);
      late_idx = -1;

      ready_rand = 1; ack_lo = 1; ack_hi = 6;
      repeat (4) run_tx(0, 0);
      run_tx(1, 0);
      ready_rand = 0; ack_lo = 3; ack_hi = 3;

      hs_q.delete();
      done_cnt = 0;
      start = 1'b1; tick(); start = 1'b0;
      tick();
      load_done = 1'b1; tick(); load_done = 1'b0;
      t = 0;
      while (hs_q.size() < 6 && t < 500) begin
         tick();
         t++;
      end
      check("mid_reset_in_stage1", stage, 1);
      reset_n = 1'b0;
      tick();
      check("mrst_busy", busy, 0);       check("mrst_done", done, 0);
      check("mrst_load_en", load_en, 0); check("mrst_valid", issue_valid, 0);
      check("mrst_addr_a", addr_a, 0);   check("mrst_addr_b", addr_b, 0);
      check("mrst_tw", tw_addr, 0);      check("mrst_stage", stage, 0);
      check("mrst_out_en", out_en, 0);   check("mrst_err", err, 0);
      reset_n = 1'b1;
      repeat (3) tick();
      check("mrst_no_done", done_cnt, 0);
      check("mrst_idle", busy, 0);
      run_tx(0, 0);

      extra_ack = 1;
      tick();
      check("err_set", err, 1);
      repeat (3) tick();
      check("err_sticky", err, 1);
      run_tx(4, 0);
      check("err_after_run", err, 1);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
